data_sram_slave: RTL and testbench
==================================

# data_sram_slave

- Memory-side responder for the CPU data SRAM interface. Serves the load/store requests issued by the pipeline.
- Read data returns one cycle after the request, lined up with the point where the mem stage latches `data_sram_rdata`.
- Holds a byte-writable RAM and a small memory-mapped config region: LED, number display, free-running timer, switches.
- Sits at the SoC top, between the CPU data port and the board I/O pins.

## Interface
- `RAM_AW`, 16: RAM word-address width (2^RAM_AW words).
- `CONF_HI`, 16'hbfaf: value of `addr[31:16]` that selects the config region.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `data_sram_en` in 1: request valid.
- `data_sram_wen` in 4: byte write enables. All zero means read.
- `data_sram_addr` in 32: byte address. Bits [1:0] are ignored; lane selection comes from `wen`.
- `data_sram_wdata` in 32: store data, already lane-aligned.
- `data_sram_rdata` out 32: registered read data.
- `hold` in 1: pipeline stall. Suppresses the access and freezes `data_sram_rdata`.
- `switch` in 16: asynchronous board switches.
- `led` out 16: LED register.
- `num_data` out 32: number-display register.
- `timer` out 32: current timer value.

## Operation
- An access occurs only when `data_sram_en && !hold`.
- Decode:
  - Config region when `addr[31:16]==CONF_HI`.
  - Everything else goes to RAM, word index `addr[RAM_AW+1:2]`. Higher bits alias.
- RAM:
  - Write: each `wen[i]` writes `wdata[8i+7:8i]`.
  - Read: returns the full word.
- Config offsets (`addr[15:0]`):
  - 0xF000 LED: RW, bits [15:0], written by `wen[1:0]`. Reads return `{16'b0,led}`.
  - 0xF010 NUM: RW, 32 bits, byte-masked.
  - 0xF020 TIMER: RW, byte-masked.
  - 0xF030 SWITCH: RO. Reads return `{16'b0,switch_sync}`; writes are ignored.
  - Any other offset: reads return 0, writes are ignored.
- Timer:
  - Increments by 1 every cycle, wrapping 0xFFFFFFFF→0.
  - An accepted write in a cycle wins over that cycle's increment. The next cycle counts from the written value.
  - `hold` does not stop the timer.
- Switches: a two-flop synchroniser produces `switch_sync`.
- Partial-`wen` writes to config registers: unwritten bytes are kept.

## Timing
- Read latency 1:
  - A request sampled at edge E yields `data_sram_rdata` valid from E until the next accepted read.
  - A config read returns the register value present just before E (timer pre-increment).
- Write cycles, idle cycles and `hold` cycles leave `data_sram_rdata` unchanged.
- Writes take effect at the sampling edge. A read in the following cycle sees the new data; there is no same-cycle read/write conflict.
- `hold=1`:
  - No RAM or config write, no read.
  - The request is expected to be re-presented after the stall.
- `switch` to readable value: 2 cycles.
- Reset (async, any time, including mid-access):
  - `data_sram_rdata`=0, `led`=0, `num_data`=0, `timer`=0, synchroniser=0.
  - RAM contents are not reset.
  - An access in flight at reset is dropped.
  - Counting resumes on the first edge after `rst` falls.

## Structure
- Shared package holds:
  - Config offsets: `CONF_LED`, `CONF_NUM`, `CONF_TIMER`, `CONF_SWITCH`.
  - `CONF_HI` default.
  - Register reset values.
- Sub-module `be_ram`: synchronous single-port RAM, parameters `AW`, 4 byte enables, registered output with enable. Holds the RAM array, with a backdoor load for simulation.
- Top handles:
  - Decode.
  - Config registers and timer.
  - Synchroniser.
  - Read mux: a region-select flop picks the RAM output or the config read register.

## Test plan
- Async reset: run timer, write LED 0x00FF, assert `rst` mid-cycle → `led`=0, `timer`=0, `rdata`=0 immediately. Timer reads 1 one cycle after the first edge after release.
- Word and byte writes:
  - Write 0x11223344 to 0x00000100 with `wen`=4'hF, then read → `rdata`=0x11223344 one cycle later.
  - Then write 0x00AA0000 with `wen`=4'b0100 and read → 0x11AA3344.
- Timer:
  - Write 0x00000100 to 0xbfaff020, then read in the next cycle → 0x00000100.
  - Read again 4 cycles after the write → 0x00000103.
- Hold:
  - Read 0x100 (0x11AA3344), then present a write of 0xDEADBEEF to 0x100 and a read of 0x104 with `hold`=1 → `rdata` stays 0x11AA3344.
  - Later read of 0x100 still returns 0x11AA3344.
- I/O:
  - `switch`=0xA5A5, wait 2 cycles, read 0xbfaff030 → 0x0000A5A5.
  - Write 0xFFFF1234 to 0xbfaff000 → `led`=0x1234.
  - Write to 0xbfaff030 → no change.
- Aliasing: with `RAM_AW`=16, write 0xCAFEF00D to 0x00040008 (wraps to word 2), then read 0x00000008 → 0xCAFEF00D.

Source files
------------

// File: rtl/data_sram_slave_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_slave_pkg
// Shared definitions for the data SRAM responder: config-region offsets,
// the default config-region select value, register reset values, the
// config-register decode enum and a byte-lane merge helper.
// -----------------------------------------------------------------------------
package data_sram_slave_pkg;

    // addr[31:16] value that selects the memory-mapped config region
    localparam logic [15:0] CONF_HI_DEFAULT = 16'hbfaf;

    // Config register offsets within the region (addr[15:0], word aligned)
    localparam logic [15:0] CONF_LED    = 16'hf000;
    localparam logic [15:0] CONF_NUM    = 16'hf010;
    localparam logic [15:0] CONF_TIMER  = 16'hf020;
    localparam logic [15:0] CONF_SWITCH = 16'hf030;

    // Register reset values
    localparam logic [15:0] LED_RST   = 16'h0000;
    localparam logic [31:0] NUM_RST   = 32'h0000_0000;
    localparam logic [31:0] TIMER_RST = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED,
        SEL_NUM,
        SEL_TIMER,
        SEL_SWITCH
    } conf_sel_e;

    // Replace the bytes of old_word whose enable bit is set with new_word's
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_slave_be_ram.sv
// -----------------------------------------------------------------------------
// be_ram
// Synchronous single-port RAM, 2^AW x 32 bits, with four byte write enables
// and a registered read output that only updates when en is high.
// A separate load port gives testbenches/bring-up a backdoor into the array;
// it takes priority over the normal write port.
//
// Ports:
//   clk        rising-edge clock
//   en         read enable: capture mem[addr] into rdata
//   we[3:0]    byte write enables for wdata lanes
//   addr       word address
//   wdata      write data (lane aligned)
//   rdata      registered read data (holds when en is low)
//   load_en    backdoor write strobe (full word)
//   load_addr  backdoor word address
//   load_data  backdoor word data
// -----------------------------------------------------------------------------
module be_ram #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);

    logic [31:0] mem [2**AW];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (en) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_sram_slave.sv
// -----------------------------------------------------------------------------
// data_sram_slave
// Memory-side responder for the CPU data SRAM port. Decodes each accepted
// request to either the byte-writable RAM or the config region (LED, number
// display, free-running timer, synchronised switches). Read data is
// registered and appears one cycle after the request.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   data_sram_en     request valid
//   data_sram_wen    byte write enables (0 = read)
//   data_sram_addr   byte address ([1:0] ignored)
//   data_sram_wdata  lane-aligned store data
//   data_sram_rdata  registered read data
//   hold             pipeline stall: suppresses access, freezes rdata
//   switch           asynchronous board switches
//   led              LED register
//   num_data         number-display register
//   timer            free-running timer
// -----------------------------------------------------------------------------
module data_sram_slave
    import data_sram_slave_pkg::*;
#(
    parameter int          RAM_AW  = 16,
    parameter logic [15:0] CONF_HI = CONF_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        hold,
    input  logic [15:0] switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic [31:0] timer
);

    logic        access;
    logic        is_conf;
    logic        is_read;
    logic        rd_access;
    logic        conf_wr;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    conf_sel_e   conf_sel;
    logic [31:0] conf_rd_word;
    logic [15:0] led_next;
    logic [15:0] switch_meta;
    logic [15:0] switch_sync;
    logic [31:0] conf_rdata_q;
    logic        sel_conf_q;
    logic [1:0]  unused_addr_lsb;

    assign unused_addr_lsb = data_sram_addr[1:0];

    assign access    = data_sram_en && !hold;
    assign is_conf   = (data_sram_addr[31:16] == CONF_HI);
    assign is_read   = (data_sram_wen == 4'b0000);
    assign rd_access = access && is_read;
    assign conf_wr   = access && is_conf && !is_read;
    assign ram_we    = (access && !is_conf) ? data_sram_wen : 4'b0000;
    assign ram_re    = rd_access && !is_conf;

    always_comb begin
        conf_sel = SEL_NONE;
        case ({data_sram_addr[15:2], 2'b00})
            CONF_LED:    conf_sel = SEL_LED;
            CONF_NUM:    conf_sel = SEL_NUM;
            CONF_TIMER:  conf_sel = SEL_TIMER;
            CONF_SWITCH: conf_sel = SEL_SWITCH;
            default:     conf_sel = SEL_NONE;
        endcase
    end

    // Register values as they stand before this edge (timer pre-increment)
    always_comb begin
        conf_rd_word = 32'h0;
        case (conf_sel)
            SEL_LED:    conf_rd_word = {16'h0, led};
            SEL_NUM:    conf_rd_word = num_data;
            SEL_TIMER:  conf_rd_word = timer;
            SEL_SWITCH: conf_rd_word = {16'h0, switch_sync};
            default:    conf_rd_word = 32'h0;
        endcase
    end

    // LED only has the two low byte lanes
    always_comb begin
        led_next[7:0]  = data_sram_wen[0] ? data_sram_wdata[7:0]  : led[7:0];
        led_next[15:8] = data_sram_wen[1] ? data_sram_wdata[15:8] : led[15:8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led          <= LED_RST;
            num_data     <= NUM_RST;
            timer        <= TIMER_RST;
            switch_meta  <= 16'h0;
            switch_sync  <= 16'h0;
            conf_rdata_q <= 32'h0;
            // Selecting the (zeroed) config read register makes rdata read 0
            // without having to reset the RAM output register.
            sel_conf_q   <= 1'b1;
        end else begin
            switch_meta <= switch;
            switch_sync <= switch_meta;

            if (conf_wr && conf_sel == SEL_LED) led <= led_next;
            if (conf_wr && conf_sel == SEL_NUM) num_data <= byte_merge(num_data, data_sram_wdata, data_sram_wen);

            // A write in the same cycle takes priority over the increment
            if (conf_wr && conf_sel == SEL_TIMER) timer <= byte_merge(timer, data_sram_wdata, data_sram_wen);
            else                                  timer <= timer + 32'd1;

            if (rd_access) begin
                sel_conf_q <= is_conf;
                if (is_conf) conf_rdata_q <= conf_rd_word;
            end
        end
    end

    be_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .clk       (clk),
        .en        (ram_re),
        .we        (ram_we),
        .addr      (data_sram_addr[RAM_AW+1:2]),
        .wdata     (data_sram_wdata),
        .rdata     (ram_rdata),
        .load_en   (1'b0),
        .load_addr ({RAM_AW{1'b0}}),
        .load_data (32'h0)
    );

    assign data_sram_rdata = sel_conf_q ? conf_rdata_q : ram_rdata;

endmodule

// File: tb/tb_data_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_data_sram_slave
// Directed scenarios followed by randomized traffic, each cycle compared
// against a behavioural model of the responder kept in this bench.
// -----------------------------------------------------------------------------
module tb_data_sram_slave;

    localparam int          AW      = 16;
    localparam logic [15:0] CONF_HI = 16'hbfaf;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hold;
    logic [15:0] switch_in;
    logic [15:0] led;
    logic [31:0] num_data;
    logic [31:0] timer;

    int n_cmp = 0;
    int n_err = 0;
    string phase = "init";

    // Reference model state
    logic [31:0] ram_m [int];
    logic [15:0] led_m;
    logic [31:0] num_m;
    logic [31:0] timer_m;
    logic [31:0] rdata_m;
    bit          rd_known;
    logic [15:0] s1_m;
    logic [15:0] s2_m;

    data_sram_slave #(
        .RAM_AW  (AW),
        .CONF_HI (CONF_HI)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .hold            (hold),
        .switch          (switch_in),
        .led             (led),
        .num_data        (num_data),
        .timer           (timer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", phase, tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        led_m    = 16'h0;
        num_m    = 32'h0;
        timer_m  = 32'h0;
        rdata_m  = 32'h0;
        rd_known = 1'b1;
        s1_m     = 16'h0;
        s2_m     = 16'h0;
    endtask

    // One clock edge of the responder, described by its observable rules
    task automatic model_edge();
        bit          acc;
        bit          conf;
        logic [15:0] off;
        int          idx;
        logic [31:0] tnext;
        logic [31:0] tmp;
        acc   = en && !hold;
        conf  = (addr[31:16] == CONF_HI);
        off   = {addr[15:2], 2'b00};
        idx   = int'(addr[AW+1:2]);
        tnext = timer_m + 32'd1;
        if (acc && wen == 4'b0000) begin
            rd_known = 1'b1;
            if (conf) begin
                case (off)
                    16'hf000: rdata_m = {16'h0, led_m};
                    16'hf010: rdata_m = num_m;
                    16'hf020: rdata_m = timer_m;
                    16'hf030: rdata_m = {16'h0, s2_m};
                    default:  rdata_m = 32'h0;
                endcase
            end else if (ram_m.exists(idx)) begin
                rdata_m = ram_m[idx];
            end else begin
                rd_known = 1'b0;
            end
        end else if (acc) begin
            if (conf) begin
                case (off)
                    16'hf000: begin
                        tmp   = bmerge({16'h0, led_m}, wdata, {2'b00, wen[1:0]});
                        led_m = tmp[15:0];
                    end
                    16'hf010: num_m = bmerge(num_m, wdata, wen);
                    16'hf020: tnext = bmerge(timer_m, wdata, wen);
                    default: ;
                endcase
            end else if (ram_m.exists(idx)) begin
                ram_m[idx] = bmerge(ram_m[idx], wdata, wen);
            end else if (wen == 4'hf) begin
                ram_m[idx] = wdata;
            end
        end
        timer_m = tnext;
        s2_m    = s1_m;
        s1_m    = switch_in;
    endtask

    task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic h);
        en = e; wen = w; addr = a; wdata = d; hold = h;
        @(posedge clk);
        model_edge();
        #1;
        if (rd_known) check("rdata", rdata, rdata_m);
        check("led", {16'h0, led}, {16'h0, led_m});
        check("num", num_data, num_m);
        check("timer", timer, timer_m);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rand_ram_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[17:2] = 16'(idx);
        if (a[31:16] == CONF_HI) a[31] = ~a[31];
        return a;
    endfunction

    initial begin
        logic [15:0] offs [5];
        offs[0] = 16'hf000; offs[1] = 16'hf010; offs[2] = 16'hf020;
        offs[3] = 16'hf030; offs[4] = 16'hf044;

        rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
        hold = 1'b0; switch_in = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset_state";
        check("rdata", rdata, 32'h0);
        check("led", {16'h0, led}, 32'h0);
        check("timer", timer, 32'h0);
        check("num", num_data, 32'h0);
        rst = 1'b0;

        // Async reset mid-cycle
        phase = "async_reset";
        repeat (5) idle();
        cyc(1'b1, 4'hf, 32'hbfaff000, 32'h000000ff, 1'b0);
        check("led_set", {16'h0, led}, 32'h00ff);
        cyc(1'b1, 4'h0, 32'hbfaff000, 32'h0, 1'b0);
        en = 1'b1; wen = 4'h0; addr = 32'hbfaff020;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("led_now", {16'h0, led}, 32'h0);
        check("timer_now", timer, 32'h0);
        check("rdata_now", rdata, 32'h0);
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 4'h0, 32'hbfaff020, 32'h0, 1'b0);
        check("timer_rd0", rdata, 32'h0);
        cyc(1'b1, 4'h0, 32'hbfaff020, 32'h0, 1'b0);
        check("timer_rd1", rdata, 32'h1);

        // Word and byte writes
        phase = "ram_wr";
        cyc(1'b1, 4'hf, 32'h00000100, 32'h11223344, 1'b0);
        cyc(1'b1, 4'h0, 32'h00000100, 32'h0, 1'b0);
        check("word", rdata, 32'h11223344);
        cyc(1'b1, 4'b0100, 32'h00000100, 32'h00aa0000, 1'b0);
        cyc(1'b1, 4'h0, 32'h00000100, 32'h0, 1'b0);
        check("byte", rdata, 32'h11aa3344);

        // Timer write and count
        phase = "timer";
        cyc(1'b1, 4'hf, 32'hbfaff020, 32'h00000100, 1'b0);
        cyc(1'b1, 4'h0, 32'hbfaff020, 32'h0, 1'b0);
        check("next", rdata, 32'h00000100);
        idle();
        idle();
        cyc(1'b1, 4'h0, 32'hbfaff020, 32'h0, 1'b0);
        check("plus3", rdata, 32'h00000103);

        // Hold
        phase = "hold";
        cyc(1'b1, 4'h0, 32'h00000100, 32'h0, 1'b0);
        cyc(1'b1, 4'hf, 32'h00000100, 32'hdeadbeef, 1'b1);
        check("held_wr", rdata, 32'h11aa3344);
        cyc(1'b1, 4'h0, 32'h00000104, 32'h0, 1'b1);
        check("held_rd", rdata, 32'h11aa3344);
        cyc(1'b1, 4'h0, 32'h00000100, 32'h0, 1'b0);
        check("after", rdata, 32'h11aa3344);

        // Board I/O
        phase = "io";
        switch_in = 16'ha5a5;
        idle();
        idle();
        cyc(1'b1, 4'h0, 32'hbfaff030, 32'h0, 1'b0);
        check("switch", rdata, 32'h0000a5a5);
        cyc(1'b1, 4'hf, 32'hbfaff000, 32'hffff1234, 1'b0);
        check("led", {16'h0, led}, 32'h1234);
        cyc(1'b1, 4'hf, 32'hbfaff030, 32'h12345678, 1'b0);
        cyc(1'b1, 4'h0, 32'hbfaff030, 32'h0, 1'b0);
        check("switch_ro", rdata, 32'h0000a5a5);

        // Aliasing above the RAM size
        phase = "alias";
        cyc(1'b1, 4'hf, 32'h00040008, 32'hcafef00d, 1'b0);
        cyc(1'b1, 4'h0, 32'h00000008, 32'h0, 1'b0);
        check("wrap", rdata, 32'hcafef00d);

        // Randomized traffic
        phase = "random";
        for (int i = 0; i < 16; i++) cyc(1'b1, 4'hf, rand_ram_addr(i), $urandom, 1'b0);
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [3:0]  w;
            if ($urandom_range(7) == 0) switch_in = 16'($urandom);
            if ($urandom_range(2) == 0) begin
                a = {CONF_HI, offs[$urandom_range(4)]};
                a[1:0] = 2'($urandom);
            end else begin
                a = rand_ram_addr(int'($urandom_range(15)));
            end
            w = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            cyc($urandom_range(7) != 0, w, a, $urandom, $urandom_range(3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
